mem_master: RTL

Bus-master sequencer that drives the 16x8 synchronous memory's address, enable, read/write and write-data lines on behalf of the CPU datapath. It accepts single read or write requests over a valid/ready handshake and runs one memory transaction per request. It captures read data after a configurable latency and returns exactly one response per request, in order. It sits between the control unit and the `memory` block.

---
 rtl/mem_master_pkg.sv | 28 ++
 rtl/mem_lat_counter.sv | 42 ++++
 rtl/mem_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_master_pkg : shared types/constants for the mem_master bus sequencer    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package mem_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3
`ifdef MEM_MASTER_VERIFY_EN
    ,
    ST_VISSUE = 3'd4,
    ST_VWAIT  = 3'd5
`endif
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 3;
  localparam int LAT_CNT_W    = 2;

endpackage
`default_nettype wire

// File: rtl/mem_lat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lat_counter : loadable down-counter, done while the count is zero       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mem_lat_counter
  import mem_master_pkg::*;
#(
  parameter int CNT_W = LAT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_master : single-request bus master for the 16x8 synchronous memory.     |
// | Optional write read-back verify: define MEM_MASTER_VERIFY_EN.  Rev 1.0      |
// +----------------------------------------------------------------------------+
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] address_bus,
  output logic              mem_enable,
  output logic              read_write,
  output logic [DATA_W-1:0] data_bus_in,
  input  logic [DATA_W-1:0] data_bus_out,
  output logic              busy
);

  if ((READ_LAT < READ_LAT_MIN) || (READ_LAT > READ_LAT_MAX)) begin : g_bad_read_lat
    $error("mem_master: READ_LAT out of range 1..3");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LAT - 1);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                req_ready_q, req_ready_d;
  logic [ADDR_W-1:0]   address_bus_q, address_bus_d;
  logic                mem_enable_q, mem_enable_d;
  logic                read_write_q, read_write_d;
  logic [DATA_W-1:0]   data_bus_in_q, data_bus_in_d;
  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_done;
`ifdef MEM_MASTER_VERIFY_EN
  logic                err_q, err_d;
`endif

  mem_lat_counter #(
    .CNT_W (LAT_CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef MEM_MASTER_VERIFY_EN
    err_d    = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ST_ISSUE;
`ifdef MEM_MASTER_VERIFY_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        if (write_q) begin
`ifdef MEM_MASTER_VERIFY_EN
          state_d = ST_VISSUE;
`else
          rdata_d = '0;
          state_d = ST_RESP;
`endif
        end else begin
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_done) begin
          rdata_d = data_bus_out;
          state_d = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
`ifdef MEM_MASTER_VERIFY_EN
      ST_VISSUE: begin
        cnt_load = 1'b1;
        state_d  = ST_VWAIT;
      end
      ST_VWAIT: begin
        if (cnt_done) begin
          rdata_d = data_bus_out;
          err_d   = (data_bus_out != wdata_q);
          state_d = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Bus lines are registered, so they follow the state being entered.
    mem_enable_d  = 1'b0;
    read_write_d  = RW_READ;
    address_bus_d = '0;
    data_bus_in_d = '0;
    if (state_d == ST_ISSUE) begin
      mem_enable_d  = 1'b1;
      address_bus_d = addr_d;
      read_write_d  = write_d ? RW_WRITE : RW_READ;
      data_bus_in_d = write_d ? wdata_d : '0;
    end
`ifdef MEM_MASTER_VERIFY_EN
    else if (state_d == ST_VISSUE) begin
      mem_enable_d  = 1'b1;
      address_bus_d = addr_d;
      read_write_d  = RW_READ;
    end
`endif

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      req_ready_q   <= 1'b0;
      address_bus_q <= '0;
      mem_enable_q  <= 1'b0;
      read_write_q  <= RW_READ;
      data_bus_in_q <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      req_ready_q   <= req_ready_d;
      address_bus_q <= address_bus_d;
      mem_enable_q  <= mem_enable_d;
      read_write_q  <= read_write_d;
      data_bus_in_q <= data_bus_in_d;
    end
  end

`ifdef MEM_MASTER_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready   = req_ready_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign address_bus = address_bus_q;
  assign mem_enable  = mem_enable_q;
  assign read_write  = read_write_q;
  assign data_bus_in = data_bus_in_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire
